// File: rtl/exu_muldiv_if.sv
// Execute-stage M-extension bus: operands and instruction from ID/EX, plus
// result, write-back address and pipeline control returned by the unit.
//   master : ID/EX side, drives op_1_i/op_2_i/inst_i/wb_addr_i
//   slave  : exu_muldiv, drives result_o/wb_addr_o/done_o/stall_req_o/busy_o
interface exu_muldiv_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ISA_LEN = 32
);
  logic [XLEN-1:0]    op_1_i;
  logic [XLEN-1:0]    op_2_i;
  logic [ISA_LEN-1:0] inst_i;
  logic [4:0]         wb_addr_i;
  logic [XLEN-1:0]    result_o;
  logic [4:0]         wb_addr_o;
  logic               done_o;
  logic               stall_req_o;
  logic               busy_o;

  modport master (
    output op_1_i, op_2_i, inst_i, wb_addr_i,
    input  result_o, wb_addr_o, done_o, stall_req_o, busy_o
  );

  modport slave (
    input  op_1_i, op_2_i, inst_i, wb_addr_i,
    output result_o, wb_addr_o, done_o, stall_req_o, busy_o
  );
endinterface

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add and divides by restoring division, both on
// operand magnitudes over 32 iterations; signs are applied when the result is
// registered. Divide-by-zero and signed overflow finish without iterating.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : squash the instruction in EX (highest priority)
//   bus (slave)   : op_1_i, op_2_i, inst_i, wb_addr_i in;
//                   result_o, wb_addr_o, done_o, stall_req_o, busy_o out
module exu_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  exu_muldiv_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       funct3_q;
  logic             sign1_q;
  logic             sign2_q;
  // mul: {partial product high, multiplier shifting out}; div: [31:0] is dividend/quotient
  logic [63:0]      acc_q;
  // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0]  mcand_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       wb_addr_q;

  // Instruction decode and operand preparation
  logic [2:0]      funct3_c;
  logic            is_m_c;
  logic            start_c;
  logic            op1_signed_c;
  logic            op2_signed_c;
  logic            s1_c;
  logic            s2_c;
  logic [XLEN-1:0] mag1_c;
  logic [XLEN-1:0] mag2_c;
  logic            div_zero_c;
  logic            div_ovf_c;
  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic            unused_inst_bits_c;

  assign funct3_c = bus.inst_i[14:12];
  assign is_m_c   = (bus.inst_i[6:0] == OPC_OP) && (bus.inst_i[31:25] == F7_MULDIV);
  assign start_c  = (state_q == S_IDLE) && is_m_c && !flush;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
  assign op1_signed_c = (funct3_c == 3'b001) || (funct3_c == 3'b010) ||
                        (funct3_c == 3'b100) || (funct3_c == 3'b110);
  assign op2_signed_c = (funct3_c == 3'b001) || (funct3_c == 3'b100) ||
                        (funct3_c == 3'b110);
  assign s1_c   = op1_signed_c && bus.op_1_i[XLEN-1];
  assign s2_c   = op2_signed_c && bus.op_2_i[XLEN-1];
  assign mag1_c = s1_c ? (~bus.op_1_i + XLEN'(1)) : bus.op_1_i;
  assign mag2_c = s2_c ? (~bus.op_2_i + XLEN'(1)) : bus.op_2_i;

  assign div_zero_c = funct3_c[2] && (bus.op_2_i == '0);
  assign div_ovf_c  = funct3_c[2] && !funct3_c[0] &&
                      (bus.op_1_i == INT_MIN) && (bus.op_2_i == '1);
  assign special_c  = div_zero_c || div_ovf_c;

  // funct3[1] selects remainder for the divide group
  always_comb begin
    special_res_c = '1;
    if (div_zero_c) begin
      special_res_c = funct3_c[1] ? bus.op_1_i : '1;
    end else begin
      special_res_c = funct3_c[1] ? '0 : INT_MIN;
    end
  end

  assign unused_inst_bits_c = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

  // One shift-add multiply step
  logic [XLEN:0] mul_sum_c;
  logic [63:0]   mul_acc_nxt_c;

  assign mul_sum_c     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_acc_nxt_c = {mul_sum_c, acc_q[31:1]};

  // One restoring divide step on a 33-bit partial remainder
  logic [XLEN:0]   div_shift_c;
  logic [XLEN:0]   div_diff_c;
  logic            div_ok_c;
  logic [XLEN-1:0] div_rem_nxt_c;
  logic [XLEN-1:0] div_quo_nxt_c;

  assign div_shift_c   = {rem_q, acc_q[31]};
  assign div_diff_c    = div_shift_c - {1'b0, mcand_q};
  assign div_ok_c      = !div_diff_c[XLEN];
  assign div_rem_nxt_c = div_ok_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
  assign div_quo_nxt_c = {acc_q[30:0], div_ok_c};

  // Signed result from the values produced by the final iteration
  logic [63:0]     prod_c;
  logic [XLEN-1:0] mul_res_c;
  logic [XLEN-1:0] quo_c;
  logic [XLEN-1:0] rem_c;
  logic [XLEN-1:0] div_res_c;
  logic [XLEN-1:0] calc_res_c;

  assign prod_c     = (sign1_q ^ sign2_q) ? (~mul_acc_nxt_c + 64'd1) : mul_acc_nxt_c;
  assign mul_res_c  = (funct3_q[1:0] == 2'b00) ? prod_c[31:0] : prod_c[63:32];
  assign quo_c      = (sign1_q ^ sign2_q) ? (~div_quo_nxt_c + XLEN'(1)) : div_quo_nxt_c;
  assign rem_c      = sign1_q ? (~div_rem_nxt_c + XLEN'(1)) : div_rem_nxt_c;
  assign div_res_c  = funct3_q[1] ? rem_c : quo_c;
  assign calc_res_c = funct3_q[2] ? div_res_c : mul_res_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and pipeline control; flush overrides every transition
  logic done_c;
  logic stall_c;

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = special_c ? S_DONE : S_CALC;
          stall_c = 1'b1;
        end
      end
      S_CALC: begin
        stall_c = 1'b1;
        if (cnt_q == CNT_W'(31)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_c  = 1'b0;
    end
    if (rst) begin
      done_c  = 1'b0;
      stall_c = 1'b0;
    end
  end

  // Operand latch, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      funct3_q  <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else if (start_c) begin
      cnt_q     <= '0;
      funct3_q  <= funct3_c;
      sign1_q   <= s1_c;
      sign2_q   <= s2_c;
      wb_addr_q <= bus.wb_addr_i;
      rem_q     <= '0;
      acc_q     <= {32'd0, (funct3_c[2] ? mag1_c : mag2_c)};
      mcand_q   <= funct3_c[2] ? mag2_c : mag1_c;
      if (special_c) begin
        result_q <= special_res_c;
      end
    end else if ((state_q == S_CALC) && !flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (funct3_q[2]) begin
        acc_q <= {32'd0, div_quo_nxt_c};
        rem_q <= div_rem_nxt_c;
      end else begin
        acc_q <= mul_acc_nxt_c;
      end
      if (cnt_q == CNT_W'(31)) begin
        result_q <= calc_res_c;
      end
    end
  end

  assign bus.result_o    = result_q;
  assign bus.wb_addr_o   = wb_addr_q;
  assign bus.done_o      = done_c;
  assign bus.stall_req_o = stall_c;
  assign bus.busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/exu_muldiv.md
# exu_muldiv

Iterative RV32M multiply/divide unit inside the execute stage, fed directly by the ID/EX pipeline register (`op_1`, `op_2`, `inst`, `wb_addr`). It executes all eight M-extension operations with a fixed multi-cycle latency. While it works it holds the ID/EX register and everything upstream through a stall request to ctrlU. It presents one result per instruction to the EX/WB path for exactly one cycle.

## Interface
- `XLEN`, 32: operand and result width; equals `ADDR_LEN`.
- `ISA_LEN`, 32: instruction width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: ctrlU flush; squashes the instruction currently in EX.
- `op_1_i` in XLEN: rs1 value from ID/EX.
- `op_2_i` in XLEN: rs2 value from ID/EX.
- `inst_i` in ISA_LEN: instruction from ID/EX.
- `wb_addr_i` in 5: destination register from ID/EX.
- `result_o` out XLEN: operation result; valid only while `done_o` is high.
- `wb_addr_o` out 5: destination register of the completed operation.
- `done_o` out 1: one-cycle pulse; result is to be written back this cycle.
- `stall_req_o` out 1: to ctrlU; while high, ID/EX and earlier stages hold.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- Start condition: `inst_i[6:0]`=0110011 and `inst_i[31:25]`=0000001. It is evaluated only in IDLE and only with `flush` low. `funct3` = `inst_i[14:12]` selects the operation:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- On start, latch into internal registers:
  - funct3 and `wb_addr_i`.
  - Operand signs: sign of op_1 for MULH/MULHSU/DIV/REM; sign of op_2 for MULH/DIV/REM; all others unsigned.
  - Operand magnitudes.
- States:
  - IDLE: no operation in progress. On start, go to DONE if a special case applies, otherwise to CALC with the iteration counter at 0.
  - CALC: one iteration per cycle. Leave for DONE when the counter reaches 31, i.e. after 32 iterations.
  - DONE: `done_o`=1 with the final result. Always return to IDLE next cycle.
- Multiply: radix-2 shift-add of the magnitudes into a 64-bit accumulator.
  - Final sign = s1 XOR s2; two's-complement negate the 64-bit product if the sign is 1.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring division of the magnitudes; 33-bit partial remainder, quotient shifted in LSB-first from the MSB of the dividend.
  - Quotient sign = s1 XOR s2; remainder sign = s1.
- Special cases, resolved without CALC:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = `op_1_i` unmodified (signed and unsigned).
  - Signed overflow, DIV/REM with op_1=0x80000000 and op_2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `stall_req_o` = (IDLE & start & ~flush) | CALC. It is low in DONE, so the pipeline advances on the same edge that retires the result. The next instruction seen in IDLE is therefore a new one and cannot re-trigger.
- `flush` has priority over everything: any state goes to IDLE next cycle. `done_o` is forced low in the flush cycle (`done_o` = DONE & ~flush). No write-back occurs.
- Reset (`rst`=1): state IDLE, counter 0, `result_o` 0, `wb_addr_o` 0, `done_o` 0, `busy_o` 0. `stall_req_o` is 0 because it is gated by reset. Reset mid-operation abandons it silently.
- Non-M instructions: no effect; all outputs remain at their idle values.

## Timing
- Normal operation accepted at edge N: CALC occupies cycles N+1..N+32, DONE is cycle N+33. `stall_req_o` is high in cycles N..N+32 (33 cycles) and `done_o` is high only in N+33.
- Special case accepted at N: DONE is cycle N+1; `stall_req_o` is high only in cycle N.
- Back-to-back M instructions: the second starts in the cycle after DONE. There is no idle gap beyond the return to IDLE.
- `result_o` and `wb_addr_o` are registered. They are undefined-but-stable outside `done_o`, and zero after reset.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) -> `done_o` at N+33, `result_o`=0xFFFFFFEB; stall high exactly 33 cycles.
- MULH/MULHSU/MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFF and 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- DIVU/REM/DIV by 0 with op_1=0x12345678 -> DIV gives 0xFFFFFFFF and REM gives 0x12345678 at N+1; stall high 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1; REM of the same operands -> 0.
- Flush asserted at cycle N+10 of a MUL -> IDLE at N+11, no `done_o` pulse, `stall_req_o` low from N+11. Repeat with flush exactly in the DONE cycle: `done_o` must stay 0. Also assert `rst` mid-CALC: all outputs 0 on the next cycle.
